i2s_transmitter: RTL and testbench
==================================

I2S_TRANSMITTER -- requirements
Module: i2s_transmitter

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 16: bits per audio sample, MSB-first, two's complement.
REQ-002 SHALL have parameter SLOT_WIDTH, default 32: sclk periods per channel slot, and SHALL require SLOT_WIDTH >= SAMPLE_WIDTH+1.
REQ-003 SHALL have parameter CLK_DIV, default 16: clk_in cycles per sclk half-period, and SHALL require CLK_DIV >= 2.
REQ-004 SHALL have clk_in, input, 1: the single system clock; all logic is on its rising edge.
REQ-005 SHALL have rst_n_in, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have sample_in, input, SAMPLE_WIDTH: the mono sample, played on both channels.
REQ-007 SHALL have valid_in, input, 1: sample_in is valid.
REQ-008 SHALL have ready_out, output, 1: the holding register is empty.
REQ-009 SHALL have sclk_out, output, 1: I2S bit clock.
REQ-010 SHALL have ws_out, output, 1: word select (0 = left, 1 = right).
REQ-011 SHALL have sdata_out, output, 1: serial data.
REQ-012 SHALL have frame_start_out, output, 1: one-cycle pulse when the bit index enters 0.
REQ-013 SHALL have underrun_out, output, 1: one-cycle pulse when a frame loads with no new sample.

Function
REQ-014 A handshake SHALL occur when valid_in and ready_out are both 1 on a clk_in edge; the block captures sample_in into the holding register.
REQ-015 ready_out SHALL be registered and equal the inverse of the holding-register occupancy.
REQ-016 sclk_out SHALL toggle each time the divider counter reaches CLK_DIV-1; the counter then wraps to 0, giving an sclk period of 2*CLK_DIV cycles.
REQ-017 Frame bit index b (0..2*SLOT_WIDTH-1) SHALL advance, wrapping, on each cycle in which sclk_out goes 1 to 0.
REQ-018 ws_out, sdata_out and frame_start_out SHALL update only on that same cycle.
REQ-019 ws_out SHALL be 1 for b in [SLOT_WIDTH-1, 2*SLOT_WIDTH-2] and 0 otherwise, so ws leads each MSB by one bit.
REQ-020 sdata_out SHALL carry shift[SAMPLE_WIDTH-1-b] for b < SAMPLE_WIDTH.
REQ-021 sdata_out SHALL carry shift[SAMPLE_WIDTH-1-(b-SLOT_WIDTH)] for SLOT_WIDTH <= b < SLOT_WIDTH+SAMPLE_WIDTH.
REQ-022 sdata_out SHALL be 0 for every other value of b.
REQ-023 Frame load (b wraps to 0) SHALL copy the holding register to the shift register, clear the holding register, and pulse frame_start_out.
REQ-024 On a load with the holding register empty and primed=1, the shift register SHALL keep its previous sample and underrun_out SHALL pulse on the same cycle.
REQ-025 On a load with the holding register empty and primed=0, the shift register SHALL hold 0 and underrun_out SHALL NOT pulse.
REQ-026 primed SHALL set on the first handshake after reset.
REQ-027 A handshake coinciding with a load SHALL bypass sample_in directly into the shift register, with no underrun and the holding register left empty.
REQ-028 While the holding register is full, ready_out SHALL be 0 and the held sample SHALL be unaffected by sample_in.
REQ-029 Steady-state throughput SHALL be one sample per frame, i.e. 4*SLOT_WIDTH*CLK_DIV cycles per sample.

Reset
REQ-030 Assertion of rst_n_in SHALL immediately force sclk_out=0, ws_out=0, sdata_out=0, frame_start_out=0, underrun_out=0 and ready_out=1.
REQ-031 Assertion of rst_n_in SHALL also force divider=0, b=2*SLOT_WIDTH-1, holding empty, shift=0 and primed=0.
REQ-032 Reset mid-frame SHALL abandon the frame; the first sclk falling edge after release SHALL start a new frame at b=0.

Structure
REQ-033 Package i2s_pkg SHALL hold the default SLOT_WIDTH, default SAMPLE_WIDTH and the function deriving the frame length 2*SLOT_WIDTH.
REQ-034 The sclk divider SHALL be a sub-module i2s_clock_gen with outputs sclk and a one-cycle fall_strobe.

Verification
REQ-035 With CLK_DIV=2 and sample 16'hA5C3 sent before the first frame, the bench SHALL see each slot serialize A5C3 MSB-first from the bit after the ws edge, followed by 16 zero bits.
REQ-036 With no samples for 3 frames after reset, the bench SHALL see sdata_out=0 throughout and no underrun_out pulses.
REQ-037 With 16'h8001 sent once and then starvation, the bench SHALL see 16'h8001 repeat every frame and one underrun_out pulse per frame.
REQ-038 With valid_in held high over 5 frames of distinct values, the bench SHALL see every value transmitted exactly once in order, with ready_out low while the holding register is full.
REQ-039 With valid_in asserted on exactly the frame_start_out cycle, the bench SHALL see that sample in the same frame and no underrun.
REQ-040 With rst_n_in pulsed low mid-slot, the bench SHALL see all outputs 0 and ready_out=1 without waiting for a clk_in edge, then a clean restart at b=0.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared defaults and frame geometry for the I2S transmitter.
package i2s_pkg;

    localparam int DEFAULT_SAMPLE_WIDTH = 16;
    localparam int DEFAULT_SLOT_WIDTH   = 32;

    function automatic int frame_len(input int slot_width);
        return 2 * slot_width;
    endfunction

endpackage

// File: rtl/i2s_clock_gen.sv
// Bit-clock divider: toggles sclk every CLK_DIV system clocks and flags
// the cycle on which sclk is about to fall.
module i2s_clock_gen #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic rst_n,
    output logic sclk,
    output logic fall_strobe
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap        = (cnt == LAST);
    assign fall_strobe = wrap && sclk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (wrap) begin
            cnt  <= '0;
            sclk <= ~sclk;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/i2s_transmitter.sv
// Mono-to-stereo I2S transmitter with a one-deep holding register,
// same-cycle bypass at frame load and underrun signalling.
module i2s_transmitter
    import i2s_pkg::*;
#(
    parameter int SAMPLE_WIDTH = DEFAULT_SAMPLE_WIDTH,
    parameter int SLOT_WIDTH   = DEFAULT_SLOT_WIDTH,
    parameter int CLK_DIV      = 16
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                    valid_in,
    output logic                    ready_out,
    output logic                    sclk_out,
    output logic                    ws_out,
    output logic                    sdata_out,
    output logic                    frame_start_out,
    output logic                    underrun_out
);

    localparam int FRAME = frame_len(SLOT_WIDTH);
    localparam int BW    = $clog2(FRAME);
    localparam int IW    = (SAMPLE_WIDTH > 1) ? $clog2(SAMPLE_WIDTH) : 1;
    localparam logic [BW-1:0] B_LAST = BW'(FRAME - 1);

    if (SLOT_WIDTH < SAMPLE_WIDTH + 1 || CLK_DIV < 2) begin : g_bad_params
        $error("i2s_transmitter: illegal SLOT_WIDTH/SAMPLE_WIDTH/CLK_DIV");
    end

    logic                    fall;
    logic [BW-1:0]           b;
    logic [BW-1:0]           b_next;
    logic [SAMPLE_WIDTH-1:0] hold;
    logic [SAMPLE_WIDTH-1:0] shift;
    logic [SAMPLE_WIDTH-1:0] shift_next;
    logic                    full;
    logic                    full_next;
    logic                    primed;
    logic                    handshake;
    logic                    load;
    logic                    starved;
    logic                    ws_next;
    logic                    sdata_next;
    int                      idx;

    i2s_clock_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clock_gen (
        .clk        (clk_in),
        .rst_n      (rst_n_in),
        .sclk       (sclk_out),
        .fall_strobe(fall)
    );

    always_comb begin
        handshake  = valid_in && ready_out;
        b_next     = (b == B_LAST) ? '0 : b + BW'(1);
        load       = fall && (b_next == '0);
        shift_next = shift;
        full_next  = full;
        starved    = 1'b0;
        if (load) begin
            full_next = 1'b0;
            if (full) begin
                shift_next = hold;
            end else if (handshake) begin
                shift_next = sample_in;
            end else begin
                starved = primed;
            end
        end else if (handshake) begin
            full_next = 1'b1;
        end
    end

    // Left slot bits start at b=0, right slot bits at b=SLOT_WIDTH.
    always_comb begin
        idx        = int'(b_next);
        ws_next    = (idx >= SLOT_WIDTH - 1) && (idx <= FRAME - 2);
        sdata_next = 1'b0;
        if (idx < SAMPLE_WIDTH) begin
            sdata_next = shift_next[IW'(SAMPLE_WIDTH - 1 - idx)];
        end else if (idx >= SLOT_WIDTH && idx < SLOT_WIDTH + SAMPLE_WIDTH) begin
            sdata_next = shift_next[IW'(SAMPLE_WIDTH - 1 - idx + SLOT_WIDTH)];
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            b               <= B_LAST;
            ws_out          <= 1'b0;
            sdata_out       <= 1'b0;
            frame_start_out <= 1'b0;
            underrun_out    <= 1'b0;
            hold            <= '0;
            full            <= 1'b0;
            shift           <= '0;
            primed          <= 1'b0;
            ready_out       <= 1'b1;
        end else begin
            frame_start_out <= load;
            underrun_out    <= starved;
            shift           <= shift_next;
            full            <= full_next;
            ready_out       <= !full_next;
            if (fall) begin
                b         <= b_next;
                ws_out    <= ws_next;
                sdata_out <= sdata_next;
            end
            if (load) begin
                hold <= '0;
            end else if (handshake) begin
                hold <= sample_in;
            end
            if (handshake) begin
                primed <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2s_transmitter.sv
// Self-checking bench for i2s_transmitter: frame-pattern tables, directed
// corner sequences and a cycle-by-cycle arithmetic reference model.
module tb_i2s_transmitter;

    localparam int CD   = 2;
    localparam int SW   = 32;
    localparam int FR   = 64;
    localparam int FCYC = 2 * CD * FR;
    localparam logic [63:0] WS_PAT = 64'h0000_0001_FFFF_FFFE;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b1;
    logic        valid_in = 1'b0;
    logic [15:0] sample_in = '0;
    logic        ready_out, sclk_out, ws_out, sdata_out;
    logic        frame_start_out, underrun_out;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;
    int ur_cnt = 0;

    // reference model state
    int          n;
    bit          pend_v;
    logic [15:0] pend_d;
    logic [15:0] cur;
    bit          primed_m;
    bit          ready_m;
    bit          fs_m;
    bit          ur_m;
    int          hs_cnt = 0;

    typedef struct {
        logic [15:0] sample;
        logic [63:0] exp_d;
    } vec_t;

    vec_t tbl[4];

    i2s_transmitter #(
        .SAMPLE_WIDTH(16),
        .SLOT_WIDTH  (SW),
        .CLK_DIV     (CD)
    ) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .sample_in      (sample_in),
        .valid_in       (valid_in),
        .ready_out      (ready_out),
        .sclk_out       (sclk_out),
        .ws_out         (ws_out),
        .sdata_out      (sdata_out),
        .frame_start_out(frame_start_out),
        .underrun_out   (underrun_out)
    );

    initial forever #5 clk_in = ~clk_in;

    function automatic logic [63:0] frame_of(input logic [15:0] v);
        return {v, 16'h0, v, 16'h0};
    endfunction

    function automatic logic exp_bit(input int b, input logic [15:0] v);
        if (b < 16) return v[15-b];
        if (b >= SW && b < SW + 16) return v[15-(b-SW)];
        return 1'b0;
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t",
                         name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    task automatic model_reset();
        n        = 0;
        pend_v   = 0;
        pend_d   = '0;
        cur      = '0;
        primed_m = 0;
        ready_m  = 1;
        fs_m     = 0;
        ur_m     = 0;
    endtask

    // A frame boundary falls on every 64th sclk fall, the first one
    // being 2*CD clocks after reset release.
    task automatic model_step();
        bit hs;
        bit load;
        int f;
        n++;
        hs   = valid_in && ready_m;
        f    = n / (2 * CD);
        load = (n % (2 * CD) == 0) && ((f - 1) % FR == 0);
        fs_m = load;
        ur_m = 0;
        if (hs) hs_cnt++;
        if (load) begin
            if (pend_v) begin
                cur    = pend_d;
                pend_v = 0;
            end else if (hs) begin
                cur = sample_in;
            end else if (primed_m) begin
                ur_m = 1;
            end
        end else if (hs) begin
            pend_v = 1;
            pend_d = sample_in;
        end
        if (hs) primed_m = 1;
        ready_m = !pend_v;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk_in or negedge rst_n_in);
            if (!rst_n_in) model_reset();
            else model_step();
        end
    end

    initial forever begin
        @(negedge clk_in);
        if (chk_en) begin
            int f;
            int b;
            f = n / (2 * CD);
            b = (f == 0) ? FR - 1 : (f - 1) % FR;
            check("sclk", 64'(sclk_out), 64'((n / CD) % 2));
            check("ws", 64'(ws_out), 64'(b >= SW - 1 && b <= FR - 2));
            check("sdata", 64'(sdata_out), 64'(exp_bit(b, cur)));
            check("frame_start", 64'(frame_start_out), 64'(fs_m));
            check("underrun", 64'(underrun_out), 64'(ur_m));
            check("ready", 64'(ready_out), 64'(ready_m));
        end
    end

    initial forever begin
        @(negedge clk_in);
        if (underrun_out) ur_cnt++;
    end

    task automatic wait_fall(output bit ok);
        ok = 0;
        for (int i = 0; i < 4 * CD + 4; i++) begin
            @(negedge clk_in);
            if (sclk_out) begin ok = 1; break; end
        end
        if (!ok) return;
        ok = 0;
        for (int i = 0; i < 4 * CD + 4; i++) begin
            @(negedge clk_in);
            if (!sclk_out) begin ok = 1; break; end
        end
    endtask

    task automatic capture(output logic [63:0] d, output logic [63:0] w);
        bit ok;
        d  = '0;
        w  = '0;
        ok = 0;
        for (int i = 0; i < 2 * FCYC; i++) begin
            @(negedge clk_in);
            if (frame_start_out) begin ok = 1; break; end
        end
        if (!ok) begin timeout("frame_start_wait"); return; end
        d[63] = sdata_out;
        w[63] = ws_out;
        for (int k = 1; k < 64; k++) begin
            wait_fall(ok);
            if (!ok) begin timeout("sclk_fall_wait"); return; end
            d[63-k] = sdata_out;
            w[63-k] = ws_out;
        end
    endtask

    task automatic send(input logic [15:0] v);
        bit ok;
        ok = 0;
        for (int i = 0; i < 2 * FCYC; i++) begin
            @(negedge clk_in);
            if (ready_m) begin ok = 1; break; end
        end
        if (!ok) begin timeout("ready_wait"); return; end
        sample_in = v;
        valid_in  = 1;
        @(posedge clk_in);
        #1 valid_in = 0;
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        #1 rst_n_in = 0;
        repeat (2) @(negedge clk_in);
        rst_n_in = 1;
    endtask

    logic [63:0] d;
    logic [63:0] w;
    logic [15:0] vals[5];
    int          u0;

    initial begin
        tbl[0] = '{16'hA5C3, 64'hA5C3_0000_A5C3_0000};
        tbl[1] = '{16'h8001, 64'h8001_0000_8001_0000};
        tbl[2] = '{16'hFFFF, 64'hFFFF_0000_FFFF_0000};
        tbl[3] = '{16'h0001, 64'h0001_0000_0001_0000};
        vals   = '{16'h1357, 16'h2468, 16'hFACE, 16'h0F0F, 16'hC001};

        #3 rst_n_in = 0;
        chk_en = 1;
        repeat (3) @(negedge clk_in);
        check("rst_sclk", 64'(sclk_out), 64'd0);
        check("rst_ws", 64'(ws_out), 64'd0);
        check("rst_sdata", 64'(sdata_out), 64'd0);
        check("rst_fs", 64'(frame_start_out), 64'd0);
        check("rst_ur", 64'(underrun_out), 64'd0);
        check("rst_ready", 64'(ready_out), 64'd1);
        rst_n_in = 1;

        // idle after reset: silent frames, no underrun
        u0 = ur_cnt;
        for (int i = 0; i < 3; i++) begin
            capture(d, w);
            check("idle_data", d, 64'd0);
            check("idle_ws", w, WS_PAT);
        end
        check("idle_underruns", 64'(ur_cnt - u0), 64'd0);

        do_reset();
        for (int i = 0; i < 4; i++) begin
            send(tbl[i].sample);
            capture(d, w);
            check($sformatf("tbl%0d_data", i), d, tbl[i].exp_d);
            check($sformatf("tbl%0d_ws", i), w, WS_PAT);
        end

        // single sample then starvation: repeats with one underrun/frame
        do_reset();
        send(16'h8001);
        u0 = ur_cnt;
        for (int i = 0; i < 3; i++) begin
            capture(d, w);
            check("starve_data", d, frame_of(16'h8001));
        end
        check("starve_underruns", 64'(ur_cnt - u0), 64'd2);

        // valid held high across five frames
        u0 = hs_cnt;
        fork
            begin
                for (int c = 0; c < 8 * FCYC; c++) begin
                    int k;
                    @(negedge clk_in);
                    k = hs_cnt - u0;
                    if (k >= 5) break;
                    valid_in  = 1;
                    sample_in = vals[k];
                end
                valid_in = 0;
            end
            begin
                logic [63:0] sd;
                logic [63:0] sw;
                for (int i = 0; i < 5; i++) begin
                    capture(sd, sw);
                    check($sformatf("stream%0d", i), sd, frame_of(vals[i]));
                end
            end
        join
        valid_in = 0;

        // handshake on the load edge is bypassed into the same frame
        begin
            bit ok;
            ok = 0;
            for (int i = 0; i < 2 * FCYC; i++) begin
                int nn;
                @(negedge clk_in);
                nn = n + 1;
                if (!pend_v && nn % (2 * CD) == 0 &&
                    ((nn / (2 * CD)) - 1) % FR == 0) begin
                    ok = 1;
                    break;
                end
            end
            if (!ok) timeout("load_edge_wait");
        end
        u0 = ur_cnt;
        sample_in = 16'h3C5A;
        valid_in  = 1;
        @(posedge clk_in);
        #1 valid_in = 0;
        capture(d, w);
        check("bypass_data", d, frame_of(16'h3C5A));
        check("bypass_underruns", 64'(ur_cnt - u0), 64'd0);

        // random traffic against the model
        for (int c = 0; c < 4 * FCYC; c++) begin
            @(negedge clk_in);
            valid_in  = ($urandom_range(0, 15) == 0);
            sample_in = 16'($urandom);
        end
        valid_in = 0;

        // asynchronous reset mid-slot with the holding register full
        send(16'h7777);
        repeat (10) @(negedge clk_in);
        @(posedge clk_in);
        #2 rst_n_in = 0;
        #1;
        check("async_sclk", 64'(sclk_out), 64'd0);
        check("async_ws", 64'(ws_out), 64'd0);
        check("async_sdata", 64'(sdata_out), 64'd0);
        check("async_fs", 64'(frame_start_out), 64'd0);
        check("async_ur", 64'(underrun_out), 64'd0);
        check("async_ready", 64'(ready_out), 64'd1);
        repeat (3) @(negedge clk_in);
        rst_n_in = 1;
        begin
            int c;
            for (c = 1; c <= 20; c++) begin
                @(negedge clk_in);
                if (frame_start_out) break;
            end
            check("restart_latency", 64'(c), 64'(2 * CD));
        end
        capture(d, w);
        check("restart_data", d, 64'd0);
        check("restart_ws", w, WS_PAT);

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
